// File: rtl/sliding_window_pkg.sv
// -----------------------------------------------------------------------------
// sliding_window_pkg
// Shared types and helpers for the sliding-window controller slice.
//   state_t : frame sequencer states (IDLE, FILL, ACTIVE, FLUSH)
//   col_w   : column counter width for an image W pixels wide
//   row_w   : row counter width for an image H lines tall
// -----------------------------------------------------------------------------
package sliding_window_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_FLUSH  = 2'd3
  } state_t;

  // A one-pixel dimension still needs a 1-bit counter to stay legal.
  function automatic int col_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  function automatic int row_w(input int h);
    return (h > 1) ? $clog2(h) : 1;
  endfunction

endpackage

// File: rtl/window_pos_counter.sv
// -----------------------------------------------------------------------------
// window_pos_counter
// Raster position counter: column wraps at W-1 and carries into the row,
// which wraps at H-1. Synchronous clear has priority over increment.
//   clk, rst_n     : clock, async active-low reset
//   i_inc          : advance one pixel position
//   i_clr          : return to (0,0)
//   o_row, o_col   : current position
//   o_last_col     : column is W-1
//   o_last_pixel   : position is (H-1, W-1)
// -----------------------------------------------------------------------------
module window_pos_counter
  import sliding_window_pkg::*;
#(
  parameter int W = 1920,
  parameter int H = 1080
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_inc,
  input  logic                i_clr,
  output logic [row_w(H)-1:0] o_row,
  output logic [col_w(W)-1:0] o_col,
  output logic                o_last_col,
  output logic                o_last_pixel
);

  localparam int unsigned CW = col_w(W);
  localparam int unsigned RW = row_w(H);
  localparam logic [CW-1:0] COL_MAX = CW'(W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(H - 1);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          w_last_row;

  assign w_last_row   = (r_row == ROW_MAX);
  assign o_last_col   = (r_col == COL_MAX);
  assign o_last_pixel = o_last_col & w_last_row;
  assign o_row        = r_row;
  assign o_col        = r_col;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_clr) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_inc) begin
      if (o_last_col) begin
        r_col <= '0;
        r_row <= w_last_row ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sliding_window_ctrl.sv
// -----------------------------------------------------------------------------
// sliding_window_ctrl
// Frame sequencer and flow controller for sliding_window_buffer. Tracks the
// raster position of a ready/valid pixel stream, drives the buffer shift and
// pad select, and flags windows that lie fully inside the image. A mid-frame
// SOF aborts the frame and pads out the rest of the line so the buffer's own
// free-running column counter is back at column 0 for the new frame.
//   clk, rst_n          : clock, async active-low reset
//   enable              : allows a new frame to start (sampled in IDLE only)
//   s_valid/s_sof       : input pixel valid / pixel is (0,0) of a frame
//   s_ready             : input pixel accepted on s_valid & s_ready
//   buf_shift_en        : buffer pixel_in_valid
//   buf_pad             : select pixel value 0 ahead of the buffer
//   win_valid, m_ready  : window valid / downstream consumes
//   win_row, win_col    : image position of the newest window pixel
//   frame_done          : pulse after the last pixel of a frame is accepted
//   sof_err             : pulse on an unexpected mid-frame SOF
//   busy                : state is not IDLE
// -----------------------------------------------------------------------------
module sliding_window_ctrl
  import sliding_window_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 1920,
  parameter int IMAGE_HEIGHT = 1080,
  parameter int WINDOW_ROWS  = 3,
  parameter int WINDOW_COLS  = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic                           s_valid,
  input  logic                           s_sof,
  output logic                           s_ready,
  output logic                           buf_shift_en,
  output logic                           buf_pad,
  output logic                           win_valid,
  input  logic                           m_ready,
  output logic [row_w(IMAGE_HEIGHT)-1:0] win_row,
  output logic [col_w(IMAGE_WIDTH)-1:0]  win_col,
  output logic                           frame_done,
  output logic                           sof_err,
  output logic                           busy
);

  localparam int unsigned CW = col_w(IMAGE_WIDTH);
  localparam int unsigned RW = row_w(IMAGE_HEIGHT);
  localparam logic [RW-1:0] ROW_WIN       = RW'(WINDOW_ROWS - 1);
  localparam logic [CW-1:0] COL_WIN       = CW'(WINDOW_COLS - 1);
  localparam logic [RW-1:0] ROW_FILL_LAST = RW'((WINDOW_ROWS > 1) ? WINDOW_ROWS - 2 : 0);
  localparam state_t        ST_FIRST      = (WINDOW_ROWS > 1) ? ST_FILL : ST_ACTIVE;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [RW-1:0]   w_row;
  logic [CW-1:0]   w_col;
  logic            w_last_col;
  logic            w_last_pixel;
  logic            w_adv;
  logic            w_inc;
  logic            w_clr;
  logic            w_frame_done_nxt;
  logic            w_sof_err_nxt;

  logic            r_win_valid;
  logic [RW-1:0]   r_win_row;
  logic [CW-1:0]   r_win_col;
  logic            r_frame_done;
  logic            r_sof_err;

  window_pos_counter #(
    .W (IMAGE_WIDTH),
    .H (IMAGE_HEIGHT)
  ) u_pos (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_inc        (w_inc),
    .i_clr        (w_clr),
    .o_row        (w_row),
    .o_col        (w_col),
    .o_last_col   (w_last_col),
    .o_last_pixel (w_last_pixel)
  );

  // The buffer may only shift when the current window is consumed or empty.
  assign w_adv = m_ready | ~r_win_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    s_ready          = 1'b0;
    buf_shift_en     = 1'b0;
    buf_pad          = 1'b0;
    w_inc            = 1'b0;
    w_clr            = 1'b0;
    w_frame_done_nxt = 1'b0;
    w_sof_err_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Junk pixels are accepted and dropped; no acceptance while in reset.
        s_ready = rst_n & enable & w_adv;
        if (s_valid & s_sof & rst_n & enable & w_adv) begin
          buf_shift_en = 1'b1;
          w_inc        = 1'b1;
          w_state_nxt  = ST_FIRST;
        end
      end
      ST_FILL, ST_ACTIVE: begin
        if (s_valid & s_sof) begin
          // SOF is held off; pad the line out unless already at column 0.
          w_sof_err_nxt = 1'b1;
          if (w_col == '0) begin
            w_clr       = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_FLUSH;
          end
        end else begin
          s_ready = w_adv;
          if (s_valid & w_adv) begin
            buf_shift_en = 1'b1;
            w_inc        = 1'b1;
            if (w_last_pixel) begin
              w_frame_done_nxt = 1'b1;
              w_state_nxt      = ST_IDLE;
            end else if ((r_state == ST_FILL) && w_last_col && (w_row == ROW_FILL_LAST)) begin
              w_state_nxt = ST_ACTIVE;
            end
          end
        end
      end
      ST_FLUSH: begin
        if (w_adv) begin
          buf_shift_en = 1'b1;
          buf_pad      = 1'b1;
          w_inc        = 1'b1;
          if (w_last_col) begin
            w_clr       = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Window qualification updates on the same edge the buffer shifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win_valid  <= 1'b0;
      r_win_row    <= '0;
      r_win_col    <= '0;
      r_frame_done <= 1'b0;
      r_sof_err    <= 1'b0;
    end else begin
      r_frame_done <= w_frame_done_nxt;
      r_sof_err    <= w_sof_err_nxt;
      if (buf_shift_en & ~buf_pad) begin
        r_win_valid <= (w_row >= ROW_WIN) & (w_col >= COL_WIN);
        r_win_row   <= w_row;
        r_win_col   <= w_col;
      end else if (buf_pad | m_ready) begin
        r_win_valid <= 1'b0;
      end
    end
  end

  assign win_valid  = r_win_valid;
  assign win_row    = r_win_row;
  assign win_col    = r_win_col;
  assign frame_done = r_frame_done;
  assign sof_err    = r_sof_err;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sliding_window_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sliding_window_ctrl
// Directed scenarios with randomized valid gaps and backpressure for an
// 8x6 image and 3x3 window. The reference tracks the frame as a linear pixel
// index (row = idx / W, col = idx % W) and derives window validity and the
// expected raster order of consumed windows from image geometry.
// -----------------------------------------------------------------------------
module tb_sliding_window_ctrl;

  localparam int W    = 8;
  localparam int H    = 6;
  localparam int WR   = 3;
  localparam int WC   = 3;
  localparam int NPIX = W * H;
  localparam int WPR  = W - WC + 1;
  localparam int NWIN = (H - WR + 1) * WPR;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       s_valid;
  logic       s_sof;
  logic       m_ready;
  logic       s_ready;
  logic       buf_shift_en;
  logic       buf_pad;
  logic       win_valid;
  logic [2:0] win_row;
  logic [2:0] win_col;
  logic       frame_done;
  logic       sof_err;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  int n_win, n_fd, n_se, n_pad, n_sh;

  typedef enum {M_IDLE, M_FRAME, M_FLUSH} mmode_t;
  mmode_t mode;
  int     pos;
  bit     e_wv;
  int     e_row, e_col;
  bit     e_fd, e_se;
  int     exp_idx;
  bit     m_acc;

  sliding_window_ctrl #(
    .IMAGE_WIDTH  (W),
    .IMAGE_HEIGHT (H),
    .WINDOW_ROWS  (WR),
    .WINDOW_COLS  (WC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .s_valid      (s_valid),
    .s_sof        (s_sof),
    .s_ready      (s_ready),
    .buf_shift_en (buf_shift_en),
    .buf_pad      (buf_pad),
    .win_valid    (win_valid),
    .m_ready      (m_ready),
    .win_row      (win_row),
    .win_col      (win_col),
    .frame_done   (frame_done),
    .sof_err      (sof_err),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mode = M_IDLE; pos = 0; e_wv = 0; e_row = 0; e_col = 0;
    e_fd = 0; e_se = 0; exp_idx = 0; m_acc = 0;
  endtask

  task automatic clr_counts();
    n_win = 0; n_fd = 0; n_se = 0; n_pad = 0; n_sh = 0;
  endtask

  // One clock: check outputs at the falling edge, then advance the reference.
  task automatic step();
    bit adv, e_rdy, e_sh, e_pad, mid;
    int r, c;
    @(negedge clk);
    adv = m_ready || !e_wv;
    e_rdy = 0; e_sh = 0; e_pad = 0; mid = 0;
    case (mode)
      M_IDLE:  e_rdy = enable && adv;
      M_FRAME: begin mid = s_valid && s_sof; e_rdy = !mid && adv; end
      default: begin e_sh = adv; e_pad = adv; end
    endcase
    m_acc = s_valid && e_rdy;
    if (m_acc && (mode != M_IDLE || s_sof)) e_sh = 1;

    chk("s_ready", s_ready, e_rdy);
    chk("buf_shift_en", buf_shift_en, e_sh);
    chk("buf_pad", buf_pad, e_pad);
    chk("busy", busy, mode != M_IDLE);
    chk("win_valid", win_valid, e_wv);
    chk("win_row", win_row, e_row);
    chk("win_col", win_col, e_col);
    chk("frame_done", frame_done, e_fd);
    chk("sof_err", sof_err, e_se);

    if (buf_shift_en) n_sh++;
    if (buf_pad)      n_pad++;
    if (frame_done)   n_fd++;
    if (sof_err)      n_se++;
    if (win_valid && m_ready) begin
      chk("order_row", win_row, WR - 1 + exp_idx / WPR);
      chk("order_col", win_col, WC - 1 + exp_idx % WPR);
      exp_idx++;
      n_win++;
    end

    if (e_sh && !e_pad) begin
      r = pos / W; c = pos % W;
      e_wv = (r >= WR - 1) && (c >= WC - 1);
      e_row = r; e_col = c;
    end else if (e_sh || m_ready) begin
      e_wv = 0;
    end
    e_fd = 0;
    e_se = mid;
    case (mode)
      M_IDLE: if (m_acc && s_sof) begin mode = M_FRAME; pos = 1; exp_idx = 0; end
      M_FRAME: begin
        if (mid) begin
          if (pos % W == 0) begin mode = M_IDLE; pos = 0; end
          else mode = M_FLUSH;
        end else if (m_acc) begin
          if (pos == NPIX - 1) begin e_fd = 1; mode = M_IDLE; pos = 0; end
          else pos++;
        end
      end
      default: if (adv) begin
        pos++;
        if (pos % W == 0) begin mode = M_IDLE; pos = 0; end
      end
    endcase
    @(posedge clk);
    #1;
  endtask

  // Offer npix pixels (SOF on the first); valid is held once raised.
  task automatic send_frame(input int npix, input bit rnd, input int bp_at, input int en_off_at);
    int bp_left;
    int budget;
    bp_left = 5;
    for (int k = 0; k < npix; k++) begin
      if (k == en_off_at) enable = 0;
      s_sof = (k == 0);
      budget = 0;
      m_acc = 0;
      while (!m_acc) begin
        if (!s_valid) s_valid = rnd ? ($urandom_range(3) != 0) : 1'b1;
        m_ready = rnd ? 1'($urandom_range(1)) : 1'b1;
        if (k == bp_at && bp_left > 0) begin m_ready = 0; bp_left--; end
        step();
        budget++;
        if (!m_acc && budget > 100) begin
          n_tests++; n_fail++;
          $error("FAIL accept_timeout pixel=%0d observed=no-accept required=accept", k);
          s_valid = 0; s_sof = 0;
          return;
        end
      end
      s_valid = 0;
    end
    s_sof = 0;
  endtask

  task automatic drain(input int n);
    s_valid = 0; s_sof = 0; m_ready = 1;
    repeat (n) step();
  endtask

  task automatic do_reset();
    s_valid = 0; s_sof = 0;
    rst_n = 0;
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_buf_shift_en", buf_shift_en, 0);
    chk("rst_buf_pad", buf_pad, 0);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_win_row", win_row, 0);
    chk("rst_win_col", win_col, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_sof_err", sof_err, 0);
    chk("rst_busy", busy, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1; enable = 0; s_valid = 0; s_sof = 0; m_ready = 1;
    model_reset();
    clr_counts();
    #1;
    do_reset();
    enable = 1;

    // Full frame, continuous flow.
    clr_counts();
    send_frame(NPIX, 0, -1, -1);
    drain(3);
    chk("full_windows", n_win, NWIN);
    chk("full_frame_done", n_fd, 1);

    // Backpressure for 5 cycles while a window is pending.
    clr_counts();
    send_frame(NPIX, 0, 30, -1);
    drain(3);
    chk("bp_windows", n_win, NWIN);
    chk("bp_frame_done", n_fd, 1);

    // Pre-frame junk.
    clr_counts();
    m_ready = 1;
    repeat (3) begin s_valid = 1; s_sof = 0; step(); end
    s_valid = 0;
    chk("junk_windows", n_win, 0);
    chk("junk_shifts", n_sh, 0);
    send_frame(NPIX, 0, -1, -1);
    drain(3);
    chk("junk_then_frame_windows", n_win, NWIN);

    // Mid-frame SOF at (3,5): previous frame stops after 29 pixels.
    clr_counts();
    send_frame(3 * W + 5, 0, -1, -1);
    send_frame(NPIX, 0, -1, -1);
    drain(3);
    chk("abort_sof_err", n_se, 1);
    chk("abort_pads", n_pad, W - 5);
    chk("abort_windows", n_win, 9 + NWIN);
    chk("abort_frame_done", n_fd, 1);

    // Enable dropped mid-frame; next SOF held off until enable returns.
    clr_counts();
    send_frame(NPIX, 0, -1, 10);
    drain(3);
    chk("en_low_frame_done", n_fd, 1);
    chk("en_low_windows", n_win, NWIN);
    clr_counts();
    s_valid = 1; s_sof = 1;
    repeat (5) step();
    chk("en_low_no_shift", n_sh, 0);
    enable = 1;
    send_frame(NPIX, 0, -1, -1);
    drain(3);
    chk("en_high_windows", n_win, NWIN);

    // Async reset at (4,3), then a randomized frame.
    clr_counts();
    send_frame(4 * W + 3, 0, -1, -1);
    do_reset();
    clr_counts();
    send_frame(NPIX, 1, -1, -1);
    drain(6);
    chk("post_reset_windows", n_win, NWIN);
    chk("post_reset_frame_done", n_fd, 1);

    // Randomized flow-control frames.
    repeat (3) begin
      clr_counts();
      send_frame(NPIX, 1, -1, -1);
      drain(6);
      chk("rand_windows", n_win, NWIN);
      chk("rand_frame_done", n_fd, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
